pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_pkg.sv | 77 +++++++
 rtl/pipe_stage_reg_sat_counter.sv | 31 +++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and payload layout for the pipeline stage registers.
// The ID/EX payload layout lives here so that every stage boundary agrees
// on what a NOP looks like.
package pipe_stage_reg_pkg;

    // Control encodings shared with the stall controller and datapath.
    localparam logic        RstEnable    = 1'b1;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    // Width of the packed ID/EX payload.
    localparam int IDEX_W = 128;

    // ID/EX payload, most significant field first. The reserved field pads
    // the payload to a round 128 bits and must be driven to zero.
    typedef struct packed {
        logic [14:0] rsvd;
        logic [31:0] link_addr;
        logic [31:0] reg2;
        logic [31:0] reg1;
        logic        wreg;
        logic [4:0]  wd;
        logic [2:0]  alusel;
        logic [7:0]  aluop;
    } idex_payload_t;

    // Per-cycle action of a stage register, in priority order.
    typedef enum logic [2:0] {
        ACT_RESET  = 3'd0,
        ACT_FLUSH  = 3'd1,
        ACT_BUBBLE = 3'd2,
        ACT_LOAD   = 3'd3,
        ACT_HOLD   = 3'd4
    } stage_act_e;

    // Build the packed ID/EX payload from its fields.
    function automatic logic [IDEX_W-1:0] pack_idex(
        input logic [7:0]  aluop,
        input logic [2:0]  alusel,
        input logic [4:0]  wd,
        input logic        wreg,
        input logic [31:0] reg1,
        input logic [31:0] reg2,
        input logic [31:0] link_addr
    );
        idex_payload_t p;
        p.rsvd      = '0;
        p.link_addr = link_addr;
        p.reg2      = reg2;
        p.reg1      = reg1;
        p.wreg      = wreg;
        p.wd        = wd;
        p.alusel    = alusel;
        p.aluop     = aluop;
        return p;
    endfunction

    // Split a packed ID/EX payload back into its fields.
    function automatic idex_payload_t unpack_idex(input logic [IDEX_W-1:0] raw);
        idex_payload_t p;
        p = raw;
        return p;
    endfunction

    // The bubble payload: no operation, no register write.
    localparam logic [IDEX_W-1:0] IDEX_NOP = pack_idex(
        EXE_NOP_OP, EXE_RES_NOP, NOPRegAddr, WriteDisable,
        ZeroWord, ZeroWord, ZeroWord
    );

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
// Clear wins over a same-cycle increment; the count sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic at_max;

    // Saturation detect: an increment at the ceiling is dropped.
    assign at_max = (count == CNT_MAX);

    // Count register: reset, then clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register placed between stage STAGE and STAGE+1.
// Carries a payload, a valid bit and a delay-slot flag; reacts to the shared
// stall vector and the exception flush, and counts bubbles and held cycles.
//
// Handshake: there is no ready/valid back-pressure on this block. out_valid
// marks a real instruction in the register; flow is controlled purely by
// the stall vector. up_stop without dn_stop turns the register into a
// bubble, up_stop with dn_stop holds it, and no up_stop loads it. All
// outputs are registered, so no input reaches an output combinationally.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W    = 128,
    parameter int                STALL_W   = 6,
    parameter int                STAGE     = 2,   // legal range 0..STALL_W-1
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(IDEX_NOP),
    parameter int                CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_dslot,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_dslot,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);

    logic       up_stop;
    logic       dn_stop;
    stage_act_e act;
    logic       bubble_inc;
    logic       hold_inc;

    // Only the two stall bits around this boundary matter here.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign up_stop = stall[STAGE];

    // The last boundary has no downstream stall bit; treat it as never stopped.
    generate
        if (STAGE + 1 < STALL_W) begin : g_dn_stop
            assign dn_stop = stall[STAGE+1];
        end else begin : g_dn_last
            assign dn_stop = NoStop;
        end
    endgenerate

    // Decode this cycle's action in strict priority order.
    always_comb begin
        act = ACT_HOLD;
        if (rst == RstEnable) begin
            act = ACT_RESET;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (up_stop == Stop && dn_stop == NoStop) begin
            act = ACT_BUBBLE;
        end else if (up_stop == NoStop) begin
            // A load while downstream is stopped is a stall-controller
            // fault; the register still loads so the pipeline keeps moving.
            act = ACT_LOAD;
        end else begin
            act = ACT_HOLD;
        end
    end

    assign bubble_inc = (act == ACT_BUBBLE);
    assign hold_inc   = (act == ACT_HOLD);

    // Stage register: reset/flush kill the contents, a bubble kills the
    // instruction but keeps the delay-slot flag, load takes upstream values.
    always_ff @(posedge clk) begin
        case (act)
            ACT_RESET, ACT_FLUSH: begin
                out_valid <= 1'b0;
                out_data  <= NOP_VALUE;
                out_dslot <= 1'b0;
            end
            ACT_BUBBLE: begin
                out_valid <= 1'b0;
                out_data  <= NOP_VALUE;
            end
            ACT_LOAD: begin
                out_valid <= in_valid;
                out_data  <= in_data;
                out_dslot <= in_dslot;
            end
            default: begin
                // Hold: nothing changes.
            end
        endcase
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (hold_inc),
        .count (hold_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the stage register.
module tb_pipe_stage_reg;

    localparam int DATA_W  = 128;
    localparam int STALL_W = 6;
    localparam int STAGE   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_dslot;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_dslot;
    logic               cnt_clr;
    logic [CNT_W-1:0]   bubble_cnt;
    logic [CNT_W-1:0]   hold_cnt;

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .STALL_W (STALL_W),
        .STAGE   (STAGE),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dslot   (in_dslot),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_dslot  (out_dslot),
        .cnt_clr    (cnt_clr),
        .bubble_cnt (bubble_cnt),
        .hold_cnt   (hold_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fault  = 0;
    logic [DATA_W-1:0] exp_q[$];

    // Behavioural model state: what the register should be holding.
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_dslot;
    int                m_bub;
    int                m_hold;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model, from the stage's rules.
    task automatic model_edge();
        logic up;
        logic dn;
        up = stall[STAGE];
        dn = (STAGE + 1 < STALL_W) ? stall[STAGE+1] : 1'b0;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_dslot = 1'b0;
            m_bub = 0; m_hold = 0;
        end else begin
            if (flush) begin
                m_valid = 1'b0; m_data = '0; m_dslot = 1'b0;
            end else if (!up) begin
                if (dn) begin
                    n_fault++;
                    $display("note: stall controller fault, load with downstream stop at %0t", $time);
                end
                m_valid = in_valid; m_data = in_data; m_dslot = in_dslot;
            end else if (!dn) begin
                m_valid = 1'b0; m_data = '0;
                if (m_bub < CNT_MAX) m_bub++;
            end else begin
                if (m_hold < CNT_MAX) m_hold++;
            end
            if (cnt_clr) begin
                m_bub = 0; m_hold = 0;
            end
        end
        exp_q.push_back(m_data);
    endtask

    // ---------------- driver ----------------
    // One edge: inputs are already set; update the model, then compare
    // everything 1 ns after the edge.
    task automatic step();
        logic [DATA_W-1:0] exp_data;
        @(posedge clk);
        model_edge();
        #1;
        exp_data = exp_q.pop_front();
        check("out_data",   out_data,   exp_data);
        check("out_valid",  DATA_W'(out_valid),  DATA_W'(m_valid));
        check("out_dslot",  DATA_W'(out_dslot),  DATA_W'(m_dslot));
        check("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(m_bub));
        check("hold_cnt",   DATA_W'(hold_cnt),   DATA_W'(m_hold));
    endtask

    task automatic drive_idle();
        rst = 1'b0; stall = '0; flush = 1'b0; cnt_clr = 1'b0;
        in_valid = 1'b0; in_data = '0; in_dslot = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] a5;
        int k;
        drive_idle();
        a5 = {(DATA_W/8){8'hA5}};

        // Reset with live-looking inputs.
        rst = 1'b1; in_data = a5; in_valid = 1'b1;
        step(); step();
        check("rst_valid", DATA_W'(out_valid), '0);
        check("rst_data",  out_data, '0);
        check("rst_dslot", DATA_W'(out_dslot), '0);
        check("rst_bub",   DATA_W'(bubble_cnt), '0);
        check("rst_hold",  DATA_W'(hold_cnt), '0);

        // Load.
        rst = 1'b0; stall = 6'b000000;
        in_data = DATA_W'(32'h1234); in_valid = 1'b1; in_dslot = 1'b1;
        step();
        check("load_data",  out_data, DATA_W'(32'h1234));
        check("load_valid", DATA_W'(out_valid), DATA_W'(1));
        check("load_dslot", DATA_W'(out_dslot), DATA_W'(1));

        // Bubble for 3 cycles.
        stall = 6'b000100; in_dslot = 1'b0; in_data = DATA_W'(32'hBEEF);
        repeat (3) step();
        check("bub_valid", DATA_W'(out_valid), '0);
        check("bub_data",  out_data, '0);
        check("bub_dslot", DATA_W'(out_dslot), DATA_W'(1));
        check("bub_cnt3",  DATA_W'(bubble_cnt), DATA_W'(3));
        check("bub_hold0", DATA_W'(hold_cnt), '0);

        // Hold 0x55 for 4 cycles.
        stall = 6'b000000; in_data = DATA_W'(8'h55); in_valid = 1'b1;
        step();
        stall = 6'b001100; in_data = DATA_W'(8'h99);
        repeat (4) begin
            step();
            check("hold_data",  out_data, DATA_W'(8'h55));
            check("hold_valid", DATA_W'(out_valid), DATA_W'(1));
        end
        check("hold_cnt4", DATA_W'(hold_cnt), DATA_W'(4));
        stall = 6'b000000; in_data = DATA_W'(8'h66);
        step();
        check("after_hold", out_data, DATA_W'(8'h66));

        // Flush beats a load.
        flush = 1'b1; in_data = DATA_W'(8'h77); in_dslot = 1'b1;
        step();
        check("flush_valid", DATA_W'(out_valid), '0);
        check("flush_data",  out_data, '0);
        check("flush_dslot", DATA_W'(out_dslot), '0);
        check("flush_bub",   DATA_W'(bubble_cnt), DATA_W'(3));
        check("flush_hold",  DATA_W'(hold_cnt), DATA_W'(4));
        flush = 1'b0;

        // Saturation, then clear during a bubble.
        stall = 6'b000100;
        repeat (20) step();
        check("sat_bub", DATA_W'(bubble_cnt), DATA_W'(15));
        cnt_clr = 1'b1;
        step();
        check("clr_bub0", DATA_W'(bubble_cnt), '0);
        cnt_clr = 1'b0;
        step();
        check("clr_bub1", DATA_W'(bubble_cnt), DATA_W'(1));

        // Random traffic; stall masks mostly contiguous from stage 0, as the
        // stall controller produces, with the occasional arbitrary vector.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            cnt_clr  = ($urandom_range(0, 19) == 0);
            k        = $urandom_range(0, STALL_W);
            stall    = STALL_W'((1 << k) - 1);
            if ($urandom_range(0, 7) == 0) stall = STALL_W'($urandom);
            in_valid = 1'($urandom);
            in_dslot = 1'($urandom);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
